// File: rtl/ad_mux_sequencer.sv
// ad_mux_sequencer: drives ad_mux ch_sel through the enabled channels and
// emits a {valid, channel, last} tag aligned with the mux data_out.
module ad_mux_sequencer #(
    parameter int CH_CNT      = 64,
    parameter int MUX_LATENCY = 2,
    localparam int CW         = $clog2(CH_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_CNT-1:0] ch_enable,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              ready,
    output logic [CW-1:0]     ch_sel,
    output logic              busy,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic              out_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // DRAIN always lasts at least one cycle so a zero-latency build still
    // passes through it before returning to IDLE.
    localparam int         DRAIN_CYC = (MUX_LATENCY > 0) ? MUX_LATENCY : 1;
    localparam logic [3:0] DRAIN_END = 4'(DRAIN_CYC - 1);

    state_t              state_q, state_d;
    logic [CH_CNT-1:0]   mask_q, mask_d;
    logic [CW-1:0]       ch_sel_q, ch_sel_d;
    logic [3:0]          drain_cnt_q, drain_cnt_d;
    logic                issue;
    logic                tag_last;

    function automatic logic [CW-1:0] lowest_set(input logic [CH_CNT-1:0] m);
        lowest_set = '0;
        for (int i = CH_CNT - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CW'(i);
        end
    endfunction

    function automatic logic [CW-1:0] highest_set(input logic [CH_CNT-1:0] m);
        highest_set = '0;
        for (int i = 0; i < CH_CNT; i++) begin
            if (m[i]) highest_set = CW'(i);
        end
    endfunction

    // Lowest set bit strictly above cur; returns cur when there is none.
    function automatic logic [CW-1:0] next_above(input logic [CH_CNT-1:0] m,
                                                 input logic [CW-1:0]     cur);
        next_above = cur;
        for (int i = CH_CNT - 1; i >= 0; i--) begin
            if (m[i] && (CW'(i) > cur)) next_above = CW'(i);
        end
    endfunction

    // State, mask snapshot, channel select and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            ch_sel_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_sel_q    <= ch_sel_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic: issue decision, channel stepping, wrap and drain.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_sel_d    = ch_sel_q;
        drain_cnt_d = drain_cnt_q;
        issue       = 1'b0;
        tag_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (ch_enable != '0)) begin
                    mask_d   = ch_enable;
                    ch_sel_d = lowest_set(ch_enable);
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (ready) begin
                    issue = 1'b1;
                    if (ch_sel_q == highest_set(mask_q)) begin
                        tag_last = 1'b1;
                        if (continuous) begin
                            ch_sel_d = lowest_set(mask_q);
                        end else begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = '0;
                        end
                    end else begin
                        ch_sel_d = next_above(mask_q, ch_sel_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_END) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ch_sel = ch_sel_q;
    assign busy   = (state_q != ST_IDLE);

    generate
        if (MUX_LATENCY > 0) begin : g_line
            logic          vld_line_q  [MUX_LATENCY];
            logic          last_line_q [MUX_LATENCY];
            logic [CW-1:0] ch_line_q   [MUX_LATENCY];

            // Tag delay line matching the mux pipeline; never stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUX_LATENCY; i++) begin
                        vld_line_q[i]  <= 1'b0;
                        last_line_q[i] <= 1'b0;
                        ch_line_q[i]   <= '0;
                    end
                end else begin
                    vld_line_q[0]  <= issue;
                    last_line_q[0] <= tag_last;
                    ch_line_q[0]   <= ch_sel_q;
                    for (int i = 1; i < MUX_LATENCY; i++) begin
                        vld_line_q[i]  <= vld_line_q[i-1];
                        last_line_q[i] <= last_line_q[i-1];
                        ch_line_q[i]   <= ch_line_q[i-1];
                    end
                end
            end

            assign out_valid = vld_line_q[MUX_LATENCY-1];
            assign out_ch    = ch_line_q[MUX_LATENCY-1];
            assign out_last  = last_line_q[MUX_LATENCY-1];
        end else begin : g_direct
            assign out_valid = issue;
            assign out_ch    = ch_sel_q;
            assign out_last  = tag_last;
        end
    endgenerate

endmodule

// File: tb/tb_ad_mux_sequencer.sv
// Bench for ad_mux_sequencer: a latency-2 and a latency-0 instance share the
// stimulus and are checked every cycle against a list-based scan model.
module tb_ad_mux_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, continuous, stop, ready;
    logic [7:0] ch_enable;

    logic [2:0] a_ch_sel, a_out_ch, b_ch_sel, b_out_ch;
    logic       a_busy, a_out_valid, a_out_last;
    logic       b_busy, b_out_valid, b_out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ad_mux_sequencer #(.CH_CNT(8), .MUX_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .ch_enable(ch_enable), .start(start),
        .continuous(continuous), .stop(stop), .ready(ready),
        .ch_sel(a_ch_sel), .busy(a_busy), .out_valid(a_out_valid),
        .out_ch(a_out_ch), .out_last(a_out_last)
    );

    ad_mux_sequencer #(.CH_CNT(8), .MUX_LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .ch_enable(ch_enable), .start(start),
        .continuous(continuous), .stop(stop), .ready(ready),
        .ch_sel(b_ch_sel), .busy(b_busy), .out_valid(b_out_valid),
        .out_ch(b_out_ch), .out_last(b_out_last)
    );

    // Reference model: per instance, the enabled channels as an ascending
    // list, a position in it, and a mode (0 idle, 1 scanning, 2 draining).
    int         m_mode [2];
    int         m_list [2][8];
    int         m_n    [2];
    int         m_idx  [2];
    int         m_left [2];
    logic [2:0] m_sel  [2];
    logic [4:0] hist_a [$];   // tags issued 2 and 1 cycles ago for dut_a
    bit         inited = 1'b0;
    int         valid_seen;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_sel[k]  = 3'd0;
            m_n[k]    = 0;
            m_idx[k]  = 0;
            m_left[k] = 0;
        end
        hist_a = {5'd0, 5'd0};
    endtask

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic step(input logic r, input logic s, input logic c,
                        input logic sp, input logic rd, input logic [7:0] en);
        logic       iss;
        logic       lst;
        logic [4:0] cur;
        logic [4:0] exp_t;
        logic [2:0] o_sel, o_ch;
        logic       o_busy, o_v, o_l;
        @(negedge clk);
        rst = r; start = s; continuous = c; stop = sp; ready = rd; ch_enable = en;
        #1;
        for (int k = 0; k < 2; k++) begin
            iss = (m_mode[k] == 1) && !sp && rd;
            lst = iss && (m_idx[k] == m_n[k] - 1);
            cur = {iss, m_sel[k], lst};
            exp_t = (k == 0) ? hist_a[0] : cur;
            o_sel  = (k == 0) ? a_ch_sel    : b_ch_sel;
            o_busy = (k == 0) ? a_busy      : b_busy;
            o_v    = (k == 0) ? a_out_valid : b_out_valid;
            o_ch   = (k == 0) ? a_out_ch    : b_out_ch;
            o_l    = (k == 0) ? a_out_last  : b_out_last;
            if (inited) begin
                chk((k == 0) ? "ch_sel_L2" : "ch_sel_L0", {5'd0, o_sel}, {5'd0, m_sel[k]});
                chk((k == 0) ? "busy_L2" : "busy_L0", {7'd0, o_busy}, {7'd0, (m_mode[k] != 0)});
                chk((k == 0) ? "out_valid_L2" : "out_valid_L0", {7'd0, o_v}, {7'd0, exp_t[4]});
                if (exp_t[4]) begin
                    chk((k == 0) ? "out_ch_L2" : "out_ch_L0", {5'd0, o_ch}, {5'd0, exp_t[3:1]});
                    chk((k == 0) ? "out_last_L2" : "out_last_L0", {7'd0, o_l}, {7'd0, exp_t[0]});
                end
                if (k == 0 && o_v === 1'b1) valid_seen++;
            end
            if (k == 0 && !r) begin
                void'(hist_a.pop_front());
                hist_a.push_back(cur);
            end
            if (!r) begin
                case (m_mode[k])
                    0: if (s && en != 8'd0) begin
                        m_n[k] = 0;
                        for (int b = 0; b < 8; b++) begin
                            if (en[b]) begin
                                m_list[k][m_n[k]] = b;
                                m_n[k]++;
                            end
                        end
                        m_idx[k]  = 0;
                        m_sel[k]  = 3'(m_list[k][0]);
                        m_mode[k] = 1;
                    end
                    1: if (sp) begin
                        m_mode[k] = 2;
                        m_left[k] = (k == 0) ? 2 : 1;
                    end else if (rd) begin
                        if (m_idx[k] == m_n[k] - 1) begin
                            if (c) begin
                                m_idx[k] = 0;
                                m_sel[k] = 3'(m_list[k][0]);
                            end else begin
                                m_mode[k] = 2;
                                m_left[k] = (k == 0) ? 2 : 1;
                            end
                        end else begin
                            m_idx[k]++;
                            m_sel[k] = 3'(m_list[k][m_idx[k]]);
                        end
                    end
                    default: begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_mode[k] = 0;
                    end
                endcase
            end
        end
        if (r) begin
            model_reset();
            inited = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; ready = 1'b0;
        ch_enable = 8'd0;
        valid_seen = 0;

        // Reset and explicit reset-state check
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk); #1;
        chk("rst_ch_sel", {5'd0, a_ch_sel}, 8'd0);
        chk("rst_busy", {7'd0, a_busy}, 8'd0);
        chk("rst_out_valid", {7'd0, a_out_valid}, 8'd0);
        chk("rst_out_ch", {5'd0, a_out_ch}, 8'd0);
        chk("rst_out_last", {7'd0, a_out_last}, 8'd0);

        // Single pass over 1,2,5,7
        step(0, 1, 0, 0, 1, 8'hA6);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 8'hA6);

        // Backpressure while ch_sel=3, full mask; exactly 8 valid samples
        valid_seen = 0;
        step(0, 1, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 8'h00);
        chk("bp_valid_count", 8'(valid_seen), 8'd8);

        // Continuous wrap over 0,7 then drop continuous
        step(0, 1, 1, 0, 1, 8'h81);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, 8'h81);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 8'h81);

        // Single channel, continuous: issued every ready cycle, each last
        step(0, 1, 1, 0, 1, 8'h10);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 8'h10);
        step(0, 0, 1, 1, 1, 8'h10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h10);

        // Abort at ch_sel=4, then start with an empty mask
        step(0, 1, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'hFF);
        step(0, 0, 0, 1, 1, 8'hFF);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 8'h00);

        // Reset with tags in flight
        step(0, 1, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'hFF);
        step(1, 0, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'hFF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
